// File: rtl/noc_endpoint_ni.sv
// noc_endpoint_ni: network interface between a CPU tile and its 2D-mesh router.
// TX queue with a paced send FSM and self-address loopback; RX fi-edge capture into a show-ahead FIFO.
module noc_endpoint_ni #(
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 8,
    parameter int TX_GAP    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [15:0]                  i_my_x,
    input  logic [15:0]                  i_my_y,
    input  logic                         i_cpu_tx_valid,
    output logic                         o_cpu_tx_ready,
    input  logic [15:0]                  i_cpu_tx_x,
    input  logic [15:0]                  i_cpu_tx_y,
    input  logic [31:0]                  i_cpu_tx_data,
    output logic [15:0]                  o_net_tx_x,
    output logic [15:0]                  o_net_tx_y,
    output logic [31:0]                  o_net_tx_data,
    output logic                         o_net_tx_strobe,
    input  logic [31:0]                  i_net_rx_data,
    input  logic                         i_net_rx_fi,
    input  logic                         i_cpu_rx_rd,
    output logic [31:0]                  o_cpu_rx_data,
    output logic                         o_cpu_rx_empty,
    output logic [$clog2(RXQ_DEPTH):0]   o_cpu_rx_count,
    output logic                         o_rx_overflow
);
    // state | meaning
    // IDLE  | TX queue empty, nothing to send
    // SEND  | head entry goes to the router, or loops back into the RX FIFO
    // WAIT  | gap counter running; net_tx_* held for the router
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int TA  = $clog2(TXQ_DEPTH);
    localparam int RA  = $clog2(RXQ_DEPTH);
    localparam int TAW = TA + 1;
    localparam int RAW = RA + 1;
    localparam int GW  = $clog2(TX_GAP + 1);
    localparam logic [TA:0]   TX_FULL_CNT = TAW'(TXQ_DEPTH);
    localparam logic [RA:0]   RX_FULL_CNT = RAW'(RXQ_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(TX_GAP - 1);
    localparam logic [GW-1:0] GAP_TC      = GW'(1);

    state_t        r_state, w_next;
    logic [TA:0]   r_tx_wr, r_tx_rd;
    logic [15:0]   r_txq_x [TXQ_DEPTH];
    logic [15:0]   r_txq_y [TXQ_DEPTH];
    logic [31:0]   r_txq_d [TXQ_DEPTH];
    logic [GW-1:0] r_gap;
    logic [15:0]   r_net_x, r_net_y;
    logic [31:0]   r_net_d;
    logic          r_net_stb;
    logic          r_fi_s0, r_fi_q1, r_fi_q2;
    logic [31:0]   r_rxd_s0, r_rxd_q1;
    logic [RA:0]   r_rx_wr, r_rx_rd;
    logic [31:0]   r_rxq [RXQ_DEPTH];
    logic          r_ovf;

    logic [TA:0]   w_tx_count;
    logic          w_tx_full, w_tx_empty, w_tx_push, w_tx_self;
    logic [15:0]   w_txh_x, w_txh_y;
    logic [31:0]   w_txh_d;
    logic          w_tx_pop, w_loop_push, w_net_send, w_gap_tc;
    logic          w_rx_rise, w_rx_push_req, w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [RA:0]   w_rx_count;
    logic [31:0]   w_rx_wdata;

    assign w_tx_count = r_tx_wr - r_tx_rd;
    assign w_tx_full  = (w_tx_count == TX_FULL_CNT);
    assign w_tx_empty = (w_tx_count == '0);
    assign w_txh_x    = r_txq_x[r_tx_rd[TA-1:0]];
    assign w_txh_y    = r_txq_y[r_tx_rd[TA-1:0]];
    assign w_txh_d    = r_txq_d[r_tx_rd[TA-1:0]];
    assign w_tx_self  = (w_txh_x == i_my_x) && (w_txh_y == i_my_y);
    // A pop frees a slot in the same cycle, so a full queue can still accept
    assign w_tx_push  = i_cpu_tx_valid && (!w_tx_full || w_tx_pop);
    assign w_gap_tc   = (r_gap == GAP_TC);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // WAIT goes straight to SEND when more work is queued so strobes are exactly TX_GAP apart
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!w_tx_empty) w_next = ST_SEND;
            ST_SEND: if (w_tx_pop)    w_next = ST_WAIT;
            ST_WAIT: if (w_gap_tc)    w_next = w_tx_empty ? ST_IDLE : ST_SEND;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop    = 1'b0;
        w_loop_push = 1'b0;
        w_net_send  = 1'b0;
        case (r_state)
            ST_SEND: begin
                w_tx_pop    = !(w_tx_self && w_rx_rise);
                w_loop_push = w_tx_self && !w_rx_rise;
                w_net_send  = !w_tx_self;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tx_push) begin
            r_txq_x[r_tx_wr[TA-1:0]] <= i_cpu_tx_x;
            r_txq_y[r_tx_wr[TA-1:0]] <= i_cpu_tx_y;
            r_txq_d[r_tx_wr[TA-1:0]] <= i_cpu_tx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                              r_gap <= '0;
        else if (w_tx_pop)                         r_gap <= GAP_LOAD;
        else if (r_state == ST_WAIT && r_gap != '0) r_gap <= r_gap - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_net_x   <= '0;
            r_net_y   <= '0;
            r_net_d   <= '0;
            r_net_stb <= 1'b0;
        end else begin
            r_net_stb <= w_net_send;
            if (w_net_send) begin
                r_net_x <= w_txh_x;
                r_net_y <= w_txh_y;
                r_net_d <= w_txh_d;
            end
        end
    end

    // Data rides a pipeline matched to the fi synchroniser so the captured word pairs with its edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fi_s0  <= 1'b0;
            r_fi_q1  <= 1'b0;
            r_fi_q2  <= 1'b0;
            r_rxd_s0 <= '0;
            r_rxd_q1 <= '0;
        end else begin
            r_fi_s0  <= i_net_rx_fi;
            r_fi_q1  <= r_fi_s0;
            r_fi_q2  <= r_fi_q1;
            r_rxd_s0 <= i_net_rx_data;
            r_rxd_q1 <= r_rxd_s0;
        end
    end

    assign w_rx_rise     = r_fi_q1 && !r_fi_q2;
    assign w_rx_push_req = w_rx_rise || w_loop_push;
    assign w_rx_wdata    = w_rx_rise ? r_rxd_q1 : w_txh_d;
    assign w_rx_count    = r_rx_wr - r_rx_rd;
    assign w_rx_full     = (w_rx_count == RX_FULL_CNT);
    assign w_rx_empty    = (w_rx_count == '0);
    assign w_rx_pop      = i_cpu_rx_rd && !w_rx_empty;
    assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_rx_push)                  r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)                   r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_push_req && !w_rx_push) r_ovf  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rx_push) r_rxq[r_rx_wr[RA-1:0]] <= w_rx_wdata;
    end

    assign o_cpu_tx_ready  = !w_tx_full;
    assign o_net_tx_x      = r_net_x;
    assign o_net_tx_y      = r_net_y;
    assign o_net_tx_data   = r_net_d;
    assign o_net_tx_strobe = r_net_stb;
    assign o_cpu_rx_data   = w_rx_empty ? '0 : r_rxq[r_rx_rd[RA-1:0]];
    assign o_cpu_rx_empty  = w_rx_empty;
    assign o_cpu_rx_count  = w_rx_count;
    assign o_rx_overflow   = r_ovf;

endmodule

// File: tb/tb_noc_endpoint_ni.sv
// Bench for noc_endpoint_ni: directed scenarios plus randomized TX and RX traffic
// checked against queue-based reference models.
`timescale 1ns/1ps
module tb_noc_endpoint_ni;
    localparam int TXQ_DEPTH = 4;
    localparam int RXQ_DEPTH = 8;
    localparam int TX_GAP    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] my_x = 16'd1, my_y = 16'd1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] tx_x = '0, tx_y = '0;
    logic [31:0] tx_d = '0;
    logic [15:0] net_x, net_y;
    logic [31:0] net_d;
    logic        net_stb;
    logic [31:0] rx_d = '0;
    logic        fi = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] rx_data;
    logic        rx_empty;
    logic [3:0]  rx_count;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [63:0] mon_pkt[$];
    int          mon_cyc[$];

    noc_endpoint_ni #(.TXQ_DEPTH(TXQ_DEPTH), .RXQ_DEPTH(RXQ_DEPTH), .TX_GAP(TX_GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_my_x(my_x), .i_my_y(my_y),
        .i_cpu_tx_valid(tx_valid), .o_cpu_tx_ready(tx_ready),
        .i_cpu_tx_x(tx_x), .i_cpu_tx_y(tx_y), .i_cpu_tx_data(tx_d),
        .o_net_tx_x(net_x), .o_net_tx_y(net_y), .o_net_tx_data(net_d), .o_net_tx_strobe(net_stb),
        .i_net_rx_data(rx_d), .i_net_rx_fi(fi), .i_cpu_rx_rd(rd),
        .o_cpu_rx_data(rx_data), .o_cpu_rx_empty(rx_empty), .o_cpu_rx_count(rx_count),
        .o_rx_overflow(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobed packet in mesh format with the cycle it appeared
    always @(negedge clk) begin
        if (net_stb === 1'b1) begin
            mon_pkt.push_back({net_y, net_x, net_d});
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_valid = 1'b0; fi = 1'b0; rd = 1'b0;
        clk1(); clk1();
        rst_n = 1'b1;
        mon_pkt.delete(); mon_cyc.delete();
    endtask

    task automatic test_reset();
        my_x = 16'd1; my_y = 16'd1;
        do_reset();
        n_vec++; if (net_x !== 16'h0) begin n_err++; $display("FAIL rst_net_x: got %h want 0", net_x); end
        n_vec++; if (net_y !== 16'h0) begin n_err++; $display("FAIL rst_net_y: got %h want 0", net_y); end
        n_vec++; if (net_d !== 32'h0) begin n_err++; $display("FAIL rst_net_data: got %h want 0", net_d); end
        n_vec++; if (net_stb !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b want 0", net_stb); end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
        n_vec++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", rx_empty); end
        n_vec++; if (rx_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", rx_count); end
        n_vec++; if (rx_data !== 32'h0) begin n_err++; $display("FAIL rst_rx_data: got %h want 0", rx_data); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", ovf); end
    endtask

    task automatic test_single_send();
        mon_pkt.delete(); mon_cyc.delete();
        tx_valid = 1'b1; tx_x = 16'd3; tx_y = 16'd1; tx_d = 32'h0000_00AA;
        clk1();
        tx_valid = 1'b0;
        n_vec++; if (net_stb !== 1'b0) begin n_err++; $display("FAIL t1_strobe_c0: got %b want 0", net_stb); end
        clk1();
        n_vec++; if (net_stb !== 1'b0) begin n_err++; $display("FAIL t1_strobe_c1: got %b want 0", net_stb); end
        clk1();
        n_vec++; if (net_stb !== 1'b1) begin n_err++; $display("FAIL t1_strobe_c2: got %b want 1", net_stb); end
        n_vec++; if ({net_y, net_x, net_d} !== {16'd1, 16'd3, 32'hAA})
            begin n_err++; $display("FAIL t1_packet: got %h want %h", {net_y, net_x, net_d}, {16'd1, 16'd3, 32'hAA}); end
        clk1();
        n_vec++; if (net_stb !== 1'b0) begin n_err++; $display("FAIL t1_strobe_c3: got %b want 0", net_stb); end
        n_vec++; if (net_d !== 32'hAA) begin n_err++; $display("FAIL t1_hold: got %h want aa", net_d); end
        repeat (6) clk1();
        n_vec++; if (mon_pkt.size() != 1) begin n_err++; $display("FAIL t1_strobe_count: got %0d want 1", mon_pkt.size()); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp[$];
        mon_pkt.delete(); mon_cyc.delete();
        tx_valid = 1'b1; tx_x = 16'd9; tx_y = 16'd9; tx_d = $urandom;
        exp.push_back({tx_y, tx_x, tx_d});
        clk1();
        tx_valid = 1'b0;
        clk1();
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_x = 16'(10 + i); tx_y = 16'(20 + i); tx_d = $urandom;
            exp.push_back({tx_y, tx_x, tx_d});
            clk1();
        end
        tx_valid = 1'b0;
        n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL t2_ready_full: got %b want 0", tx_ready); end
        clk1();
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_after_pop: got %b want 1", tx_ready); end
        repeat (24) clk1();
        n_vec++; if (mon_pkt.size() != exp.size())
            begin n_err++; $display("FAIL t2_strobe_count: got %0d want %0d", mon_pkt.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_pkt.size(); i++) begin
            n_vec++; if (mon_pkt[i] !== exp[i]) begin n_err++; $display("FAIL t2_order[%0d]: got %h want %h", i, mon_pkt[i], exp[i]); end
            if (i > 0) begin
                n_vec++; if (mon_cyc[i] - mon_cyc[i-1] != TX_GAP)
                    begin n_err++; $display("FAIL t2_spacing[%0d]: got %0d want %0d", i, mon_cyc[i] - mon_cyc[i-1], TX_GAP); end
            end
        end
    endtask

    task automatic test_loopback();
        mon_pkt.delete(); mon_cyc.delete();
        tx_valid = 1'b1; tx_x = 16'd1; tx_y = 16'd1; tx_d = 32'(-5);
        clk1();
        tx_valid = 1'b0;
        repeat (3) clk1();
        n_vec++; if (rx_count !== 4'd1) begin n_err++; $display("FAIL t3_count: got %0d want 1", rx_count); end
        n_vec++; if (rx_data !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL t3_data: got %h want fffffffb", rx_data); end
        n_vec++; if (rx_empty !== 1'b0) begin n_err++; $display("FAIL t3_empty: got %b want 0", rx_empty); end
        n_vec++; if (mon_pkt.size() != 0) begin n_err++; $display("FAIL t3_no_strobe: got %0d want 0", mon_pkt.size()); end
        rd = 1'b1; clk1(); rd = 1'b0;
        n_vec++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL t3_pop_empty: got %b want 1", rx_empty); end
        repeat (4) clk1();
    endtask

    task automatic test_rx_pulse();
        fi = 1'b1; rx_d = 32'd7;
        clk1(); clk1();
        n_vec++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL t4_early: got empty=%b want 1", rx_empty); end
        clk1();
        n_vec++; if (rx_count !== 4'd1) begin n_err++; $display("FAIL t4_count: got %0d want 1", rx_count); end
        n_vec++; if (rx_data !== 32'd7) begin n_err++; $display("FAIL t4_head: got %h want 7", rx_data); end
        clk1(); clk1();
        fi = 1'b0;
        repeat (5) clk1();
        n_vec++; if (rx_count !== 4'd1) begin n_err++; $display("FAIL t4_one_push: got %0d want 1", rx_count); end
        rd = 1'b1; clk1(); rd = 1'b0;
        n_vec++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL t4_pop: got empty=%b want 1", rx_empty); end
    endtask

    task automatic test_random_tx();
        logic [63:0] exp[$];
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if (tx_ready === 1'b1 && $urandom_range(2) == 0) begin
                tx_valid = 1'b1;
                tx_x = 16'(2 + $urandom_range(500));
                tx_y = 16'($urandom);
                tx_d = $urandom;
                exp.push_back({tx_y, tx_x, tx_d});
            end else begin
                tx_valid = 1'b0;
            end
            clk1();
        end
        tx_valid = 1'b0;
        repeat (TX_GAP * TXQ_DEPTH + 10) clk1();
        n_vec++; if (mon_pkt.size() != exp.size())
            begin n_err++; $display("FAIL rtx_count: got %0d want %0d", mon_pkt.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < mon_pkt.size(); i++) begin
            n_vec++; if (mon_pkt[i] !== exp[i]) begin n_err++; $display("FAIL rtx_pkt[%0d]: got %h want %h", i, mon_pkt[i], exp[i]); end
            if (i > 0) begin
                n_vec++; if (mon_cyc[i] - mon_cyc[i-1] < TX_GAP)
                    begin n_err++; $display("FAIL rtx_gap[%0d]: got %0d want >=%0d", i, mon_cyc[i] - mon_cyc[i-1], TX_GAP); end
            end
        end
    endtask

    task automatic test_random_rx();
        logic [31:0] mq[$];
        int          pend_e[$];
        logic [31:0] pend_d[$];
        logic        ovf_m;
        int          e;
        int          left;
        logic [31:0] d;
        do_reset();
        ovf_m = 1'b0; e = 0; left = 0;
        for (int c = 0; c < 400; c++) begin
            if (left > 0) left--;
            else if (fi) begin fi = 1'b0; left = $urandom_range(2); end
            else if ($urandom_range(3) == 0) begin
                fi = 1'b1; rx_d = $urandom; left = $urandom_range(3);
                pend_e.push_back(e + 3); pend_d.push_back(rx_d);
            end
            rd = (c < 200) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0);
            clk1();
            e++;
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (pend_e.size() > 0 && pend_e[0] == e) begin
                void'(pend_e.pop_front());
                d = pend_d.pop_front();
                if (mq.size() < RXQ_DEPTH) mq.push_back(d);
                else ovf_m = 1'b1;
            end
            n_vec++; if (rx_count !== 4'(mq.size()))
                begin n_err++; $display("FAIL rrx_count@%0d: got %0d want %0d", e, rx_count, mq.size()); end
            n_vec++; if (rx_empty !== (mq.size() == 0))
                begin n_err++; $display("FAIL rrx_empty@%0d: got %b want %b", e, rx_empty, mq.size() == 0); end
            n_vec++; if (ovf !== ovf_m) begin n_err++; $display("FAIL rrx_ovf@%0d: got %b want %b", e, ovf, ovf_m); end
            if (mq.size() > 0) begin
                n_vec++; if (rx_data !== mq[0]) begin n_err++; $display("FAIL rrx_head@%0d: got %h want %h", e, rx_data, mq[0]); end
            end
        end
        fi = 1'b0; rd = 1'b0;
    endtask

    task automatic test_rx_overflow();
        do_reset();
        for (int i = 0; i < RXQ_DEPTH; i++) begin
            fi = 1'b1; rx_d = 32'(100 + i);
            clk1(); fi = 1'b0; clk1(); clk1();
        end
        repeat (3) clk1();
        n_vec++; if (rx_count !== 4'd8) begin n_err++; $display("FAIL t5_full_count: got %0d want 8", rx_count); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL t5_no_ovf_yet: got %b want 0", ovf); end
        fi = 1'b1; rx_d = 32'd999;
        clk1(); fi = 1'b0;
        repeat (4) clk1();
        n_vec++; if (rx_count !== 4'd8) begin n_err++; $display("FAIL t5_count_after_drop: got %0d want 8", rx_count); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL t5_ovf: got %b want 1", ovf); end
        n_vec++; if (rx_data !== 32'd100) begin n_err++; $display("FAIL t5_head: got %0d want 100", rx_data); end
        fi = 1'b1; rx_d = 32'd555;
        clk1(); fi = 1'b0;
        clk1(); rd = 1'b1;
        clk1(); rd = 1'b0;
        n_vec++; if (rx_count !== 4'd8) begin n_err++; $display("FAIL t5_pushpop_count: got %0d want 8", rx_count); end
        n_vec++; if (rx_data !== 32'd101) begin n_err++; $display("FAIL t5_pushpop_head: got %0d want 101", rx_data); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL t5_ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_collision_and_reset();
        rd = 1'b1; repeat (7) clk1(); rd = 1'b0;
        n_vec++; if (rx_data !== 32'd555) begin n_err++; $display("FAIL t6_last_word: got %0d want 555", rx_data); end
        rd = 1'b1; clk1(); rd = 1'b0;
        n_vec++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL t6_drained: got %b want 1", rx_empty); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL t6_ovf_kept: got %b want 1", ovf); end
        rd = 1'b1; clk1(); rd = 1'b0;
        n_vec++; if (rx_count !== 4'd0) begin n_err++; $display("FAIL t6_underflow: got %0d want 0", rx_count); end
        tx_valid = 1'b1; tx_x = 16'd1; tx_y = 16'd1; tx_d = 32'h55;
        fi = 1'b1; rx_d = 32'h77;
        clk1(); tx_valid = 1'b0;
        clk1(); fi = 1'b0;
        clk1();
        n_vec++; if (rx_count !== 4'd1) begin n_err++; $display("FAIL t6_router_first_count: got %0d want 1", rx_count); end
        n_vec++; if (rx_data !== 32'h77) begin n_err++; $display("FAIL t6_router_first: got %h want 77", rx_data); end
        clk1();
        n_vec++; if (rx_count !== 4'd2) begin n_err++; $display("FAIL t6_loop_next: got %0d want 2", rx_count); end
        rd = 1'b1; clk1(); rd = 1'b0;
        n_vec++; if (rx_data !== 32'h55) begin n_err++; $display("FAIL t6_loop_word: got %h want 55", rx_data); end
        repeat (3) clk1();
        tx_valid = 1'b1; tx_x = 16'd5; tx_y = 16'd2; tx_d = 32'h1234;
        clk1(); tx_valid = 1'b0;
        clk1(); clk1(); clk1();
        n_vec++; if (net_x !== 16'd5) begin n_err++; $display("FAIL t6_sent_x: got %0d want 5", net_x); end
        rst_n = 1'b0;
        clk1();
        n_vec++; if ({net_y, net_x, net_d} !== 64'h0) begin n_err++; $display("FAIL t6_rst_net: got %h want 0", {net_y, net_x, net_d}); end
        n_vec++; if (net_stb !== 1'b0) begin n_err++; $display("FAIL t6_rst_strobe: got %b want 0", net_stb); end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL t6_rst_ready: got %b want 1", tx_ready); end
        n_vec++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL t6_rst_empty: got %b want 1", rx_empty); end
        n_vec++; if (rx_count !== 4'd0) begin n_err++; $display("FAIL t6_rst_count: got %0d want 0", rx_count); end
        n_vec++; if (rx_data !== 32'h0) begin n_err++; $display("FAIL t6_rst_rx_data: got %h want 0", rx_data); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL t6_rst_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        repeat (6) clk1();
        n_vec++; if (net_stb !== 1'b0 || mon_pkt.size() != 0 && net_d === 32'h1234)
            begin n_err++; $display("FAIL t6_no_resend: got strobe=%b data=%h want 0", net_stb, net_d); end
    endtask

    initial begin
        test_reset();
        test_single_send();
        test_back_to_back();
        test_loopback();
        test_rx_pulse();
        test_random_tx();
        test_random_rx();
        test_rx_overflow();
        mon_pkt.delete(); mon_cyc.delete();
        test_collision_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
